jt12_eg_tick: RTL

//  Global envelope timebase and per-slot step decoder feeding jt12_eg. Divides the
//  24-slot frame strobe by 3 and keeps the 15-bit envelope counter. For the slot

---
 rtl/jt12_eg_tick.sv | 91 +++++++++
 1 files changed

// File: rtl/jt12_eg_tick.sv
// jt12_eg_tick: envelope timebase (frame strobe divided by 3, 15-bit eg counter)
// and per-slot rate-to-step/increment decoder, registered one enabled cycle late.
module jt12_eg_tick (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic        zero,
   input  logic        eg_stop,
   input  logic [5:0]  rate_I,
   output logic [14:0] eg_cnt,
   output logic        tick,
   output logic        step_II,
   output logic [3:0]  inc_II
);
   // Pattern rows stored with bit n = entry for idx n
   localparam logic [7:0] P0 = 8'b1010_1010;
   localparam logic [7:0] P1 = 8'b1011_1010;
   localparam logic [7:0] P2 = 8'b1110_1110;
   localparam logic [7:0] P3 = 8'b1111_1110;
   localparam logic [7:0] Q0 = 8'b0000_0000;
   localparam logic [7:0] Q1 = 8'b1000_1000;
   localparam logic [7:0] Q2 = 8'b1010_1010;
   localparam logic [7:0] Q3 = 8'b1110_1110;

   logic [1:0]  r_cnt3;
   logic [14:0] r_eg_cnt;
   logic        r_tick;
   logic        r_step;
   logic [3:0]  r_inc;

   logic [3:0]  w_g;
   logic        w_hi;
   logic        w_top;
   logic [3:0]  w_s;
   logic [14:0] w_mask;
   logic        w_hit;
   logic [2:0]  w_idx;
   logic        w_step;
   logic [7:0]  w_p;
   logic [7:0]  w_q;
   logic [3:0]  w_base;
   logic [3:0]  w_inc;

   always_comb begin
      w_g    = rate_I[5:2];
      w_hi   = rate_I >= 6'd48;
      w_top  = rate_I >= 6'd60;
      w_s    = w_hi ? 4'd0 : 4'd11 - w_g;
      w_mask = (15'd1 << w_s) - 15'd1;
      w_hit  = (r_eg_cnt & w_mask) == 15'd0;
      w_idx  = 3'(r_eg_cnt >> w_s);
      w_step = r_tick & w_hit & (rate_I >= 6'd2);
      w_p    = rate_I[1] ? (rate_I[0] ? P3 : P2) : (rate_I[0] ? P1 : P0);
      w_q    = rate_I[1] ? (rate_I[0] ? Q3 : Q2) : (rate_I[0] ? Q1 : Q0);
      // rates 48..59 have g=12..14, so g[1:0] is the power-of-two base exponent
      w_base = 4'd1 << w_g[1:0];
      w_inc  = !w_step ? 4'd0 :
               !w_hi   ? {3'd0, w_p[w_idx]} :
               w_top   ? 4'd8 : w_base << w_q[w_idx];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt3   <= 2'd0;
         r_eg_cnt <= 15'd0;
         r_tick   <= 1'b0;
         r_step   <= 1'b0;
         r_inc    <= 4'd0;
      end else if (clk_en) begin
         r_step <= w_step;
         r_inc  <= w_inc;
         if (zero) begin
            if (eg_stop) begin
               r_tick <= 1'b0;
            end else if (r_cnt3 == 2'd2) begin
               r_cnt3   <= 2'd0;
               r_eg_cnt <= r_eg_cnt + 15'd1;
               r_tick   <= 1'b1;
            end else begin
               r_cnt3 <= r_cnt3 + 2'd1;
               r_tick <= 1'b0;
            end
         end
      end
   end

   assign eg_cnt  = r_eg_cnt;
   assign tick    = r_tick;
   assign step_II = r_step;
   assign inc_II  = r_inc;
endmodule
